// File: rtl/tetris_pkg.sv
// tetris_pkg: playfield state encoding, counter width and cell-index helper
//   state_t : SPAWN, FALL, LOCK, CLEAR, GAME_OVER
//   LINES_W : width of the cleared-line counter
//   idx     : flat grid_out bit index of cell (r, c) in a field of 'rows' rows
package tetris_pkg;
    typedef enum logic [2:0] {SPAWN, FALL, LOCK, CLEAR, GAME_OVER} state_t;
    localparam int LINES_W = 16;
    function automatic int idx(input int r, input int c, input int rows);
        return c * rows + r;
    endfunction
endpackage

// File: rtl/tetris_playfield_tick_divider.sv
// tick_divider: gravity tick generator, one tick every TICK_DIV counted cycles
//   clk, reset : clock and synchronous active-high reset
//   enable     : count this cycle
//   clear      : synchronously zero the counter
//   tick       : high on the counted cycle that wraps the counter
module tick_divider #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = enable && cnt == W'(TICK_DIV - 1);
    always_ff @(posedge clk)
        if (reset || clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tetris_playfield.sv
// tetris_playfield: locked-cell playfield with one falling rectangular piece
//   clk, reset            : clock and synchronous active-high reset
//   enable                : advance when high, freeze everything when low
//   move_left/move_right  : one-column shift requests, sampled on gravity tick
//   grid_out              : registered cell map, bit c*ROWS + r, row 0 at top
//   lines_cleared         : saturating count of removed rows
//   game_over             : a spawn collided; held until reset
//   piece_active          : a piece is falling
module tetris_playfield
    import tetris_pkg::*;
#(
    parameter int COLS     = 16,
    parameter int ROWS     = 16,
    parameter int PIECE_W  = 4,
    parameter int PIECE_H  = 2,
    parameter int SPAWN_X  = 0,
    parameter int TICK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   move_left,
    input  logic                   move_right,
    output logic [ROWS*COLS-1:0]   grid_out,
    output logic [LINES_W-1:0]     lines_cleared,
    output logic                   game_over,
    output logic                   piece_active
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    typedef logic [ROWS-1:0][COLS-1:0] field_t;

    state_t              state;
    field_t              cells, cleared, view;
    logic [ROWS*COLS-1:0] flat;
    logic [XW-1:0]       px, nx;
    logic [YW-1:0]       py, scan;
    logic                tick, spawn_hit, go_left, go_right, land, row_full;

    // Membership test keeps every index constant; cells outside the field simply never match.
    function automatic field_t footprint(input int x, input int y);
        field_t f;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[r][c] = r >= y && r < y + PIECE_H && c >= x && c < x + PIECE_W;
        return f;
    endfunction

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable && state == FALL),
        .clear  (enable && state == SPAWN),
        .tick   (tick)
    );

    // Bounds are checked on the unsigned position before any +/-1 so nothing wraps.
    assign spawn_hit = |(cells & footprint(SPAWN_X, 0));
    assign go_left   = move_left && !move_right && px != '0
                       && !(|(cells & footprint(int'(px) - 1, int'(py))));
    assign go_right  = move_right && !move_left && int'(px) + PIECE_W < COLS
                       && !(|(cells & footprint(int'(px) + 1, int'(py))));
    assign nx        = go_left ? px - 1'b1 : go_right ? px + 1'b1 : px;
    assign land      = int'(py) + PIECE_H == ROWS
                       || |(cells & footprint(int'(nx), int'(py) + 1));
    assign row_full  = &cells[scan];
    assign view      = cells | (state == FALL ? footprint(int'(px), int'(py)) : '0);

    // Rows at or above the scan row drop by one; rows below it are untouched.
    always_comb begin
        cleared = cells;
        for (int r = 1; r < ROWS; r++)
            if (r <= int'(scan)) cleared[r] = cells[r-1];
        cleared[0] = '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign flat[idx(r, c, ROWS)] = view[r][c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SPAWN;
            cells         <= '0;
            grid_out      <= '0;
            lines_cleared <= '0;
            game_over     <= 1'b0;
            piece_active  <= 1'b0;
            px            <= '0;
            py            <= '0;
            scan          <= '0;
        end else if (enable) begin
            grid_out <= flat;
            case (state)
                SPAWN: begin
                    px           <= XW'(SPAWN_X);
                    py           <= '0;
                    state        <= spawn_hit ? GAME_OVER : FALL;
                    game_over    <= spawn_hit;
                    piece_active <= !spawn_hit;
                end
                FALL: if (tick) begin
                    px <= nx;
                    if (land) begin
                        state        <= LOCK;
                        piece_active <= 1'b0;
                    end else py <= py + 1'b1;
                end
                LOCK: begin
                    cells <= cells | footprint(int'(px), int'(py));
                    scan  <= YW'(ROWS - 1);
                    state <= CLEAR;
                end
                CLEAR: begin
                    if (row_full) begin
                        cells <= cleared;
                        if (lines_cleared != '1) lines_cleared <= lines_cleared + 1'b1;
                    end else if (scan != '0) scan <= scan - 1'b1;
                    else state <= SPAWN;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_playfield.sv
// tb_tetris_playfield: directed table/sequence checks on a 4x4 field plus randomized run on a 6x6 field against a reference model
module tb_tetris_playfield;
    localparam int BC = 6, BR = 6, BPW = 2, BPH = 2, BSX = 2, BTD = 3;
    localparam int P_SPAWN = 0, P_FALL = 1, P_LOCK = 2, P_CLEAR = 3, P_OVER = 4;

    logic clk = 0;
    always #5 clk = ~clk;

    logic ra = 1, ea = 1, la = 0, rta = 0;
    logic [15:0] ga, lca;
    logic goa, paa;
    logic rb = 1, eb = 1, lb = 0, rtb = 0;
    logic [BR*BC-1:0] gb;
    logic [15:0] lcb;
    logic gob, pab;

    tetris_playfield #(.COLS(4), .ROWS(4), .PIECE_W(2), .PIECE_H(1), .SPAWN_X(0), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(ra), .enable(ea), .move_left(la), .move_right(rta),
        .grid_out(ga), .lines_cleared(lca), .game_over(goa), .piece_active(paa));

    tetris_playfield #(.COLS(BC), .ROWS(BR), .PIECE_W(BPW), .PIECE_H(BPH), .SPAWN_X(BSX), .TICK_DIV(BTD)) dut_b (
        .clk(clk), .reset(rb), .enable(eb), .move_left(lb), .move_right(rtb),
        .grid_out(gb), .lines_cleared(lcb), .game_over(gob), .piece_active(pab));

    int passed = 0, total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step_a(input logic l, input logic r);
        la = l; rta = r;
        @(posedge clk); #1;
    endtask

    task automatic wait_a(input logic want, input string name);
        int n = 0;
        while (paa !== want && n < 40) begin step_a(0, 0); n++; end
        chk(name, paa, want);
    endtask

    task automatic reset_a();
        ra = 1; step_a(0, 0); ra = 0;
    endtask

    task automatic drop_a(input int rights);
        for (int k = 0; k < rights; k++) step_a(0, 1);
        wait_a(0, "drop_lock");
        wait_a(1, "drop_spawn");
    endtask

    typedef struct packed {
        logic        ml;
        logic        mr;
        logic [15:0] grid;
        logic        pa;
        logic [15:0] lines;
    } vec_t;
    vec_t tbl[$];

    // Reference model of the 6x6 field: whole-piece "fits" checks, row removal by array copy.
    int mc[BR][BC];
    bit mg[BR][BC];
    int mph, mx, my, mcnt, mscan, mlines;
    bit mgo, mpa;

    function automatic bit fits(input int x, input int y);
        for (int i = 0; i < BPH; i++)
            for (int j = 0; j < BPW; j++) begin
                if (y + i < 0 || y + i >= BR || x + j < 0 || x + j >= BC) return 0;
                if (mc[y+i][x+j] != 0) return 0;
            end
        return 1;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit ml, input bit mr);
        bit full;
        if (r) begin
            foreach (mc[i, j]) begin mc[i][j] = 0; mg[i][j] = 0; end
            mph = P_SPAWN; mx = 0; my = 0; mcnt = 0; mscan = 0; mlines = 0; mgo = 0; mpa = 0;
            return;
        end
        if (!en) return;
        foreach (mg[i, j])
            mg[i][j] = mc[i][j] != 0 || (mph == P_FALL && i >= my && i < my + BPH && j >= mx && j < mx + BPW);
        case (mph)
            P_SPAWN: begin
                mcnt = 0; mx = BSX; my = 0;
                if (!fits(BSX, 0)) begin mph = P_OVER; mgo = 1; end
                else begin mph = P_FALL; mpa = 1; end
            end
            P_FALL: begin
                if (mcnt == BTD - 1) begin
                    mcnt = 0;
                    if (ml != mr && fits(mx + (mr ? 1 : -1), my)) mx += mr ? 1 : -1;
                    if (fits(mx, my + 1)) my++;
                    else begin mph = P_LOCK; mpa = 0; end
                end else mcnt++;
            end
            P_LOCK: begin
                for (int i = 0; i < BPH; i++)
                    for (int j = 0; j < BPW; j++) mc[my+i][mx+j] = 1;
                mscan = BR - 1; mph = P_CLEAR;
            end
            P_CLEAR: begin
                full = 1;
                for (int j = 0; j < BC; j++) if (mc[mscan][j] == 0) full = 0;
                if (full) begin
                    for (int i = mscan; i > 0; i--) mc[i] = mc[i-1];
                    for (int j = 0; j < BC; j++) mc[0][j] = 0;
                    if (mlines < 65535) mlines++;
                end else if (mscan > 0) mscan--;
                else mph = P_SPAWN;
            end
            default: ;
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [BR*BC-1:0] exp;
        logic [15:0] held;

        // Scenarios 1-3 from a fresh reset, one enabled edge per row.
        tbl.push_back('{0,0,16'h0000,1,0}); tbl.push_back('{0,0,16'h0011,1,0});
        tbl.push_back('{0,0,16'h0022,1,0}); tbl.push_back('{0,0,16'h0044,1,0});
        tbl.push_back('{0,0,16'h0088,0,0}); tbl.push_back('{0,0,16'h0000,0,0});
        tbl.push_back('{0,0,16'h0088,0,0}); tbl.push_back('{0,0,16'h0088,0,0});
        tbl.push_back('{0,0,16'h0088,0,0}); tbl.push_back('{0,0,16'h0088,0,0});
        tbl.push_back('{0,0,16'h0088,1,0}); tbl.push_back('{0,1,16'h0099,1,0});
        tbl.push_back('{0,1,16'h02A8,1,0}); tbl.push_back('{0,0,16'h4488,1,0});
        tbl.push_back('{0,0,16'h8888,0,0}); tbl.push_back('{0,0,16'h0088,0,0});
        tbl.push_back('{0,0,16'h8888,0,1}); tbl.push_back('{0,0,16'h0000,0,1});
        tbl.push_back('{0,0,16'h0000,0,1}); tbl.push_back('{0,0,16'h0000,0,1});
        tbl.push_back('{0,0,16'h0000,0,1}); tbl.push_back('{0,0,16'h0000,1,1});
        tbl.push_back('{1,0,16'h0011,1,1}); tbl.push_back('{0,1,16'h0022,1,1});
        tbl.push_back('{1,1,16'h0440,1,1}); tbl.push_back('{0,0,16'h0880,0,1});
        tbl.push_back('{0,0,16'h0000,0,1}); tbl.push_back('{0,0,16'h0880,0,1});

        reset_a();
        chk("reset_state", {ga, lca, goa, paa}, 34'h0);
        foreach (tbl[i]) begin
            step_a(tbl[i].ml, tbl[i].mr);
            chk($sformatf("table_%0d", i), {ga, lca, goa, paa}, {tbl[i].grid, tbl[i].lines, 1'b0, tbl[i].pa});
        end

        // Scenario 4: column 2/3 stack, blocked right move, landing on locked cells.
        reset_a();
        wait_a(1, "s4_spawn");
        drop_a(2); drop_a(2); drop_a(2);
        step_a(0, 0);
        step_a(0, 1);
        step_a(0, 0);
        chk("s4_move_rejected", ga, 16'hEE44);
        step_a(0, 0);
        chk("s4_bottom", {ga, paa}, {16'hEE88, 1'b0});
        wait_a(1, "s4_respawn");
        chk("s4_cleared", {ga, lca}, {16'hCC00, 16'd1});
        step_a(0, 1);
        step_a(0, 0);
        chk("s4_land_on_stack", {ga, paa}, {16'hCE20, 1'b0});
        step_a(0, 0);
        step_a(0, 0);
        chk("s4_locked_on_top", ga, 16'hCE20);

        // Scenario 5: fill columns 0/1 until the spawn collides.
        reset_a();
        wait_a(1, "s5_spawn");
        drop_a(0); drop_a(0); drop_a(0);
        wait_a(0, "s5_last_lock");
        for (int n = 0; n < 20 && !goa; n++) step_a(0, 0);
        chk("s5_game_over", {ga, lca, goa, paa}, {16'h00FF, 16'd0, 1'b1, 1'b0});
        for (int n = 0; n < 20; n++) begin
            step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("s5_frozen", {ga, lca, goa, paa}, {16'h00FF, 16'd0, 1'b1, 1'b0});
        end
        reset_a();
        chk("s5_reset", {ga, lca, goa, paa}, 34'h0);

        // Scenario 6: enable low mid-fall, then reset mid-fall.
        wait_a(1, "s6_spawn");
        step_a(0, 0);
        held = ga;
        ea = 0;
        for (int n = 0; n < 10; n++) begin
            step_a(0, 1);
            chk("s6_frozen", {ga, paa}, {held, 1'b1});
        end
        ea = 1;
        step_a(0, 0);
        chk("s6_resume_y1", ga, 16'h0022);
        step_a(0, 0);
        chk("s6_resume_y2", ga, 16'h0044);
        reset_a();
        chk("s6_reset_mid_fall", {ga, lca, goa, paa}, 34'h0);

        // Randomized run on the larger field.
        for (int n = 0; n < 6000; n++) begin
            rb  = n == 0 || $urandom_range(0, 499) == 0 || (mph == P_OVER && $urandom_range(0, 19) == 0);
            eb  = $urandom_range(0, 7) != 0;
            lb  = $urandom_range(0, 3) == 0;
            rtb = $urandom_range(0, 2) == 0;
            @(posedge clk);
            model_step(rb, eb, lb, rtb);
            #1;
            exp = '0;
            for (int r = 0; r < BR; r++)
                for (int c = 0; c < BC; c++) exp[c*BR+r] = mg[r][c];
            chk($sformatf("random_%0d", n), {gb, lcb, gob, pab}, {exp, 16'(mlines), mgo, mpa});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
